// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the multi-cycle MIPS core: opcodes, ALU-op
// codes, main-control state encodings and datapath mux selects.
package mips_ctrl_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation handed to the execute-stage ALU function decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Main-control state encodings; 12..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

endpackage

// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, driving every datapath enable and mux select.
// Memory states wait on mem_ready. STATE_W must be at least 4.
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         ID_opcode,
    input  logic               mem_ready,
    output logic [1:0]         EX_alu_op,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    state_t state_q;
    state_t state_d;

    // State register with synchronous active-low reset back to FETCH
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_d unassigned, which would infer a latch.
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (ID_opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDIEX;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // Only lw/sw reach here; the IR still holds the opcode
                state_d = (ID_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                state_d = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
            end
            S_JUMP: begin
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output decode: Moore outputs per state, plus mem_ready gating in FETCH
    always_comb begin
        EX_alu_op     = ALUOP_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        pc_src        = PCSRC_ALU;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Read instruction at PC and compute PC+4 in the same cycle
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute branch target PC + (imm << 2) speculatively
                alu_src_b = ALUB_IMM_SH;
                case (ID_opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                    default:                                        illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                EX_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                EX_alu_op     = ALUOP_SUB;
                pc_src        = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: begin
                // Unused encodings drive nothing
            end
        endcase
    end

    // Expose the state encoding zero-extended to the debug width
    assign dbg_state = STATE_W'(state_q);

endmodule
